// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter: FSM encoding, grant codes and wait limit.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHi,
    StLo,
    StDone
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  localparam int unsigned WAIT_CYCLES_MAX = 7;

endpackage

// File: rtl/sram_arb_pick.sv
// Grant selection: a lone request wins; on a tie the port not granted last wins.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic i_ireq,
  input  logic i_dreq,
  input  logic i_last,
  output logic o_grant
);

  always_comb begin
    o_grant = GRANT_I;
    if (i_ireq && i_dreq) begin
      // Fixed priority falls out of tying i_last to GRANT_I.
      o_grant = (i_last == GRANT_I) ? GRANT_D : GRANT_I;
    end else if (i_dreq) begin
      o_grant = GRANT_D;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates instruction/data ports onto a 16-bit async SRAM as two half-word phases.
// Define SRAM_ARB_RR_EN for round-robin on simultaneous requests (default: data wins).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ireq,
  input  logic [31:0] iaddr,
  output logic [31:0] iout,
  output logic        iack,
  input  logic        dreq,
  input  logic        drw,
  input  logic [31:0] daddr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        dack,
  output logic        cpu_stall,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [22:0] sram_addr,
  inout  wire  [15:0] sram_data
);

  localparam logic [2:0] WAIT_CNT = 3'(WAIT_CYCLES);

  state_e      r_state;
  state_e      w_state_next;
  logic [2:0]  r_cnt;
  logic        r_grant;
  logic        r_write;
  logic [21:0] r_addr;
  logic [31:0] r_din;
  logic [15:0] r_hi;
  logic [31:0] r_iout;
  logic [31:0] r_dout;

  logic        w_grant;
  logic        w_last;
  logic        w_start;
  logic        w_in_phase;
  logic        w_phase_end;
  logic        w_drive;
  logic [15:0] w_wdata;
  logic        w_unused_addr;

  assign w_unused_addr = ^{iaddr[31:24], iaddr[1:0], daddr[31:24], daddr[1:0]};

  assign w_start     = (r_state == StIdle) && (ireq || dreq);
  assign w_in_phase  = (r_state == StHi) || (r_state == StLo);
  assign w_phase_end = (r_cnt == WAIT_CNT);

  sram_arb_pick u_pick (
    .i_ireq  (ireq),
    .i_dreq  (dreq),
    .i_last  (w_last),
    .o_grant (w_grant)
  );

`ifdef SRAM_ARB_RR_EN
  logic r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= GRANT_I;
    end else if (w_start) begin
      r_last <= w_grant;
    end
  end

  assign w_last = r_last;
`else
  assign w_last = GRANT_I;
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (ireq || dreq) w_state_next = StHi;
      StHi:   if (w_phase_end) w_state_next = StLo;
      StLo:   if (w_phase_end) w_state_next = StDone;
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_grant <= GRANT_I;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
      r_hi    <= '0;
      r_iout  <= '0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else if (w_in_phase) begin
        r_cnt <= r_cnt + 3'd1;
      end
      if (w_start) begin
        r_grant <= w_grant;
        r_write <= (w_grant == GRANT_D) && drw;
        r_addr  <= (w_grant == GRANT_D) ? daddr[23:2] : iaddr[23:2];
        r_din   <= din;
      end
      // Read data is sampled on the final (hold) cycle of each phase.
      if (w_in_phase && w_phase_end && !r_write) begin
        if (r_state == StHi) begin
          r_hi <= sram_data;
        end else if (r_grant == GRANT_D) begin
          r_dout <= {r_hi, sram_data};
        end else begin
          r_iout <= {r_hi, sram_data};
        end
      end
    end
  end

  assign iack = (r_state == StDone) && (r_grant == GRANT_I);
  assign dack = (r_state == StDone) && (r_grant == GRANT_D);
  assign iout = r_iout;
  assign dout = r_dout;

  assign cpu_stall = (ireq && !iack) || (dreq && !dack);

  assign sram_ce_n = !w_in_phase;
  assign sram_oe_n = !(w_in_phase && !r_write);
  // The last phase cycle holds address/data with the strobe released, unless it is the only one.
  assign sram_we_n = !(w_in_phase && r_write && (!w_phase_end || (WAIT_CNT == 3'd0)));
  assign sram_addr = {r_addr, (r_state == StLo)};

  assign w_drive   = w_in_phase && r_write;
  assign w_wdata   = (r_state == StHi) ? r_din[31:16] : r_din[15:0];
  assign sram_data = w_drive ? w_wdata : 16'hzzzz;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0.
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Instance 0: WAIT_CYCLES = 2
  logic        ireq0, dreq0, drw0;
  logic [31:0] iaddr0, daddr0, din0, iout0, dout0;
  logic        iack0, dack0, stall0, ce0, oe0, we0;
  logic [22:0] addr0;
  wire  [15:0] sram_data0;

  // Instance 1: WAIT_CYCLES = 0
  logic        ireq1, dreq1, drw1;
  logic [31:0] iaddr1, daddr1, din1, iout1, dout1;
  logic        iack1, dack1, stall1, ce1, oe1, we1;
  logic [22:0] addr1;
  wire  [15:0] sram_data1;

  logic [15:0] mem0  [256];
  logic [15:0] mem1  [256];
  logic [15:0] wmem0 [256];

  for (genvar k = 0; k < 16; k++) begin : g_pu
    pullup (sram_data0[k]);
    pullup (sram_data1[k]);
  end

  assign sram_data0 = (!ce0 && !oe0) ? mem0[addr0[7:0]] : 16'hzzzz;
  assign sram_data1 = (!ce1 && !oe1) ? mem1[addr1[7:0]] : 16'hzzzz;

  sram_arbiter #(.WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst),
    .ireq(ireq0), .iaddr(iaddr0), .iout(iout0), .iack(iack0),
    .dreq(dreq0), .drw(drw0), .daddr(daddr0), .din(din0), .dout(dout0), .dack(dack0),
    .cpu_stall(stall0), .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0),
    .sram_addr(addr0), .sram_data(sram_data0)
  );

  sram_arbiter #(.WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst),
    .ireq(ireq1), .iaddr(iaddr1), .iout(iout1), .iack(iack1),
    .dreq(dreq1), .drw(drw1), .daddr(daddr1), .din(din1), .dout(dout1), .dack(dack1),
    .cpu_stall(stall1), .sram_ce_n(ce1), .sram_oe_n(oe1), .sram_we_n(we1),
    .sram_addr(addr1), .sram_data(sram_data1)
  );

  // Bus monitors sampled mid-cycle
  int we_cnt0 = 0;
  int we_cnt1 = 0;
  int both_ack = 0;
  int z_viol1 = 0;

  always @(negedge clk) begin
    if (!ce0 && !we0) wmem0[addr0[7:0]] <= sram_data0;
    if (!we0) we_cnt0 <= we_cnt0 + 1;
    if (!we1) we_cnt1 <= we_cnt1 + 1;
    if ((iack0 && dack0) || (iack1 && dack1)) both_ack <= both_ack + 1;
    if (oe1 && (sram_data1 !== 16'hFFFF)) z_viol1 <= z_viol1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts edges until an ack (edge count includes the sampling edge); gives up at 40.
  task automatic wait_ack(input bit sel1, output int cyc, output logic gi, output logic gd);
    cyc = 0;
    gi  = 1'b0;
    gd  = 1'b0;
    while (cyc < 40 && !gi && !gd) begin
      @(posedge clk);
      #1;
      cyc++;
      gi = sel1 ? iack1 : iack0;
      gd = sel1 ? dack1 : dack0;
    end
  endtask

  int   cyc;
  int   we_snap;
  logic gi, gd;
  logic exp4_i, exp4_d;

  initial begin
`ifdef SRAM_ARB_RR_EN
    exp4_i = 1'b1;
    exp4_d = 1'b0;
`else
    exp4_i = 1'b0;
    exp4_d = 1'b1;
`endif
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 16'h0000;
      mem1[i] = 16'h0000;
    end
    mem0[8'h08] = 16'hDEAD; mem0[8'h09] = 16'hBEEF;
    mem0[8'h20] = 16'hCAFE; mem0[8'h21] = 16'hF00D;
    mem0[8'h30] = 16'h0BAD; mem0[8'h31] = 16'hF00D;
    mem1[8'h20] = 16'h1111; mem1[8'h21] = 16'h2222;

    {ireq0, dreq0, drw0} = 3'b000;
    {iaddr0, daddr0, din0} = '0;
    {ireq1, dreq1, drw1} = 3'b000;
    {iaddr1, daddr1, din1} = '0;

    // A: reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("A_iack", iack0, 0);
    chk("A_dack", dack0, 0);
    chk("A_iout", iout0, 0);
    chk("A_dout", dout0, 0);
    chk("A_ce_n", ce0, 1);
    chk("A_oe_n", oe0, 1);
    chk("A_we_n", we0, 1);
    chk("A_addr", addr0, 0);
    chk("A_data_z", sram_data0, 16'hFFFF);
    chk("A_stall", stall0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // B: data read 0x10 -> words 8/9
    daddr0 = 32'h10; drw0 = 1'b0; dreq0 = 1'b1;
    @(posedge clk);
    #1;
    chk("B_addr_hi", addr0, 23'h8);
    chk("B_oe_n", oe0, 0);
    chk("B_we_n", we0, 1);
    chk("B_stall", stall0, 1);
    wait_ack(1'b0, cyc, gi, gd);
    chk("B_latency", 1 + cyc, 7);
    chk("B_dack", gd, 1);
    chk("B_iack", gi, 0);
    chk("B_dout", dout0, 32'hDEADBEEF);
    chk("B_stall_ack", stall0, 0);
    dreq0 = 1'b0;
    repeat (2) @(negedge clk);

    // C: data write 0x20 <- 0x12345678
    we_snap = we_cnt0;
    daddr0 = 32'h20; din0 = 32'h12345678; drw0 = 1'b1; dreq0 = 1'b1;
    wait_ack(1'b0, cyc, gi, gd);
    chk("C_latency", cyc, 7);
    chk("C_dack", gd, 1);
    chk("C_dout_held", dout0, 32'hDEADBEEF);
    dreq0 = 1'b0; drw0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("C_word_hi", wmem0[8'h10], 16'h1234);
    chk("C_word_lo", wmem0[8'h11], 16'h5678);
    chk("C_we_cycles", we_cnt0 - we_snap, 4);

    // D: reset during LO of a read, then a clean retry
    daddr0 = 32'h10; dreq0 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("D_in_lo", addr0, 23'h9);
    rst = 1'b1;
    #1;
    chk("D_rst_ce_n", ce0, 1);
    chk("D_rst_oe_n", oe0, 1);
    chk("D_rst_addr", addr0, 0);
    chk("D_rst_dout", dout0, 0);
    chk("D_rst_data_z", sram_data0, 16'hFFFF);
    dreq0 = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("D_rst_dack", dack0, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    dreq0 = 1'b1;
    wait_ack(1'b0, cyc, gi, gd);
    chk("D_retry_latency", cyc, 7);
    chk("D_retry_dack", gd, 1);
    chk("D_retry_dout", dout0, 32'hDEADBEEF);
    dreq0 = 1'b0;
    repeat (2) @(negedge clk);

    // E: fetch request dropped mid-transfer still completes
    iaddr0 = 32'h40; ireq0 = 1'b1;
    repeat (2) @(negedge clk);
    ireq0 = 1'b0;
    wait_ack(1'b0, cyc, gi, gd);
    chk("E_latency", 2 + cyc, 7);
    chk("E_iack", gi, 1);
    chk("E_iout", iout0, 32'hCAFEF00D);
    repeat (2) @(negedge clk);

    // F: simultaneous requests
    iaddr0 = 32'h40; daddr0 = 32'h60; drw0 = 1'b0;
    ireq0 = 1'b1; dreq0 = 1'b1;
    wait_ack(1'b0, cyc, gi, gd);
    chk("F1_latency", cyc, 7);
    chk("F1_dack", gd, 1);
    chk("F1_dout", dout0, 32'h0BADF00D);
    chk("F1_stall", stall0, 1);
`ifndef SRAM_ARB_RR_EN
    dreq0 = 1'b0;
`endif
    wait_ack(1'b0, cyc, gi, gd);
    chk("F2_latency", cyc, 8);
    chk("F2_iack", gi, 1);
    chk("F2_iout", iout0, 32'hCAFEF00D);
    dreq0 = 1'b1;
    wait_ack(1'b0, cyc, gi, gd);
    chk("F3_latency", cyc, 8);
    chk("F3_dack", gd, 1);
    wait_ack(1'b0, cyc, gi, gd);
    chk("F4_latency", cyc, 8);
    chk("F4_iack", gi, exp4_i);
    chk("F4_dack", gd, exp4_d);
    ireq0 = 1'b0; dreq0 = 1'b0;
    repeat (2) @(negedge clk);

    // G: zero-wait fetch on the second instance
    we_snap = we_cnt1;
    iaddr1 = 32'h40; ireq1 = 1'b1;
    wait_ack(1'b1, cyc, gi, gd);
    chk("G_latency", cyc, 3);
    chk("G_iack", gi, 1);
    chk("G_iout", iout1, 32'h11112222);
    chk("G_stall", stall1, 0);
    chk("G_dout", dout1, 0);
    ireq1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("G_we_never", we_cnt1 - we_snap, 0);
    chk("G_data_z", z_viol1, 0);

    chk("acks_exclusive", both_ack, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
